rib_gpio: RTL and testbench
===========================

# rib_gpio

Memory-mapped GPIO responder on slave port 3 of the rib bus, decoded at 0x2000_0000–0x2fff_ffff. It is the responder end of the rib slave interface. It accepts single-cycle writes and returns read data one clock after the read address, which matches the interconnect's registered read-address return path. It synchronises external inputs, detects rising and falling edges into sticky pending flags, and raises a level interrupt.

## Interface
- GPIO_W, 8: number of GPIO pins (1–32).
- SYNC_STAGES, 2: input synchroniser depth (≥2).
- clk  in  1  system clock; all state is updated on posedge.
- rst_n  in  1  asynchronous, active-low reset; one clock domain only.
- wr_en_i  in  1  write strobe, one transfer per cycle.
- wr_addr_i  in  32  write address; bits [7:2] select the register, all other bits are ignored.
- wr_data_i  in  32  write data.
- rd_addr_i  in  32  read address; bits [7:2] select the register, all other bits are ignored.
- rd_data_o  out  32  registered read data; reset value 0.
- gpio_i  in  GPIO_W  asynchronous pad inputs.
- gpio_o  out  GPIO_W  output data, driven from the OUT register; reset value 0.
- gpio_oe_o  out  GPIO_W  output enable, driven from the OE register; reset value 0 (all pins are inputs).
- irq_o  out  1  registered interrupt, equal to |(PEND & IEN); reset value 0.

## Operation
- Register map (byte offset), with all bits above GPIO_W-1 reading 0:
  - 0x00 OUT: read/write.
  - 0x04 OE: read/write.
  - 0x08 IN: read-only, returns the synchronised input value.
  - 0x0C RISE_EN: read/write.
  - 0x10 FALL_EN: read/write.
  - 0x14 PEND: read; writing 1 to a bit clears it.
  - 0x18 IEN: read/write.
  - 0x1C OUT_SET: write-only; writing 1 to a bit sets that OUT bit. Reads return 0.
  - 0x20 OUT_CLR: write-only; writing 1 to a bit clears that OUT bit. Reads return 0.
- Unmapped offsets: reads return 0, writes are ignored. Addresses alias every 256 bytes.
- Input path: gpio_i passes through SYNC_STAGES flops to give `sync`. A further flop holds `prev`.
  - rise = sync & ~prev & RISE_EN
  - fall = ~sync & prev & FALL_EN
- Pending update each cycle: PEND_next = (PEND & ~w1c_mask) | rise | fall.
  - A new edge in the same cycle as a W1C write to that bit leaves the bit set.
- OUT writes:
  - OUT_SET and OUT_CLR affect only the addressed register's effect; bits written 0 are unchanged.
  - A plain OUT write replaces the whole register.
- Writes with wr_en_i=0 have no effect, whatever the address.
- Reads have no side effects. Reading PEND does not clear it.
- Reset applies immediately and asynchronously:
  - Clears every register, the synchroniser and `prev`.
  - After reset release, `prev` equals 0. A pin already high when reset releases therefore generates one rising edge once it has propagated through the synchroniser, if RISE_EN is set.

## Timing
- Write: a write presented in cycle N takes effect at the posedge ending cycle N. gpio_o and gpio_oe_o reflect it from cycle N+1.
- Read: rd_addr_i presented in cycle N is sampled at the posedge ending N. rd_data_o is valid during cycle N+1 and holds until the next edge. This gives 1 cycle of latency with no wait states.
- Simultaneous read and write to the same register in cycle N: rd_data_o returns the pre-write value. A read issued in cycle N+1 returns the new value.
- Input to PEND latency: an edge on gpio_i sets PEND SYNC_STAGES+1 cycles later. irq_o asserts one cycle after PEND.
- irq_o deasserts one cycle after the W1C write, or the IEN clear, that removes the last pending-and-enabled bit.
- Back-to-back reads and writes are accepted every cycle.

## Structure
- Package rib_gpio_pkg holds:
  - register offset localparams (OFF_OUT … OFF_OUT_CLR);
  - the register-select width (6 bits, taken from addr[7:2]).
- Sub-module gpio_sync_edge, parameterised by width and stage count. It outputs `sync`, `rise_raw` and `fall_raw`; the top level applies the RISE_EN/FALL_EN masks.
- The top level contains the register file, W1C logic, the read mux with its output register, and the irq register.

## Test plan
- Reset then read: hold rst_n=0 for 3 cycles and release. Read each offset 0x00–0x20 → every read returns 0x0000_0000; gpio_o=0, gpio_oe_o=0, irq_o=0.
- Output path (GPIO_W=8):
  - Write OUT=0xA5, then OUT_SET=0x0A, then OUT_CLR=0x81. Expect gpio_o = 0xA5, then 0xAF, then 0x2E, each one cycle after its write.
  - A read of 0x00 issued in the same cycle as the 0xA5 write returns 0x00; the next read returns 0xA5.
- Edge detect and irq:
  - Set RISE_EN=0x01 and IEN=0x01. Drive gpio_i[0] 0→1 → PEND=0x01 after 3 cycles, irq_o=1 one cycle later.
  - Set FALL_EN=0x02, drive bit 1 1→0 → PEND=0x03.
- W1C collision: write PEND=0x01 in the same cycle a new rising edge on bit 0 reaches PEND → PEND bit 0 stays 1 and irq_o stays 1. A second W1C write of 0x01 with no new edge → PEND=0x02, and irq_o drops one cycle later.
- Unmapped and aliasing access:
  - Write 0xFFFF_FFFF to offset 0x3C → no register changes; a read of 0x3C returns 0.
  - Write OUT through address 0x2000_0100 → gpio_o updates, because addresses alias every 256 bytes.
- Reset mid-operation: with PEND=0xFF and irq_o=1, assert rst_n asynchronously between clock edges → irq_o, gpio_o, gpio_oe_o and rd_data_o go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rib_gpio_pkg.sv
// Shared definitions for the rib GPIO responder: register-select width and
// the word index of every mapped register (byte offset >> 2).
package rib_gpio_pkg;

    localparam int unsigned REG_SEL_W = 6;

    typedef logic [REG_SEL_W-1:0] reg_sel_t;

    localparam reg_sel_t OFF_OUT     = 6'h00;
    localparam reg_sel_t OFF_OE      = 6'h01;
    localparam reg_sel_t OFF_IN      = 6'h02;
    localparam reg_sel_t OFF_RISE_EN = 6'h03;
    localparam reg_sel_t OFF_FALL_EN = 6'h04;
    localparam reg_sel_t OFF_PEND    = 6'h05;
    localparam reg_sel_t OFF_IEN     = 6'h06;
    localparam reg_sel_t OFF_OUT_SET = 6'h07;
    localparam reg_sel_t OFF_OUT_CLR = 6'h08;

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser plus one-cycle history flop; reports unmasked rising and
// falling edges of the synchronised value.
module gpio_sync_edge #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise_raw,
    output logic [WIDTH-1:0] fall_raw
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            stage_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q <= stage_q[STAGES-1];
        end
    end

    assign sync     = stage_q[STAGES-1];
    assign rise_raw = sync & ~prev_q;
    assign fall_raw = ~sync & prev_q;

endmodule

// File: rtl/rib_gpio.sv
// GPIO responder on the rib bus: register file, write-1-to-clear pending
// flags, registered read mux and registered level interrupt.
module rib_gpio
    import rib_gpio_pkg::*;
#(
    parameter int unsigned GPIO_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [31:0]       wr_addr_i,
    input  logic [31:0]       wr_data_i,
    input  logic [31:0]       rd_addr_i,
    output logic [31:0]       rd_data_o,
    input  logic [GPIO_W-1:0] gpio_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic [GPIO_W-1:0] gpio_oe_o,
    output logic              irq_o
);

    logic [GPIO_W-1:0] out_q, out_d, oe_q, oe_d;
    logic [GPIO_W-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [GPIO_W-1:0] pend_q, pend_d, ien_q, ien_d;
    logic [GPIO_W-1:0] w1c_mask, wr_val, rd_val;
    logic [GPIO_W-1:0] sync, rise_raw, fall_raw;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              irq_q, irq_d;
    reg_sel_t          wr_sel, rd_sel;
    logic              unused_bits;

    gpio_sync_edge #(
        .WIDTH  (GPIO_W),
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (gpio_i),
        .sync     (sync),
        .rise_raw (rise_raw),
        .fall_raw (fall_raw)
    );

    // Only addr[7:2] decodes, so the map aliases every 256 bytes.
    assign wr_sel = wr_addr_i[7:2];
    assign rd_sel = rd_addr_i[7:2];
    assign wr_val = wr_data_i[GPIO_W-1:0];
    assign unused_bits = ^{wr_addr_i[31:8], wr_addr_i[1:0], rd_addr_i[31:8], rd_addr_i[1:0],
                           wr_data_i};

    always_comb begin
        out_d     = out_q;
        oe_d      = oe_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        ien_d     = ien_q;
        w1c_mask  = '0;
        if (wr_en_i) begin
            case (wr_sel)
                OFF_OUT:     out_d     = wr_val;
                OFF_OE:      oe_d      = wr_val;
                OFF_RISE_EN: rise_en_d = wr_val;
                OFF_FALL_EN: fall_en_d = wr_val;
                OFF_PEND:    w1c_mask  = wr_val;
                OFF_IEN:     ien_d     = wr_val;
                OFF_OUT_SET: out_d     = out_q | wr_val;
                OFF_OUT_CLR: out_d     = out_q & ~wr_val;
                default:     ;
            endcase
        end
        // New edges win over a simultaneous clear of the same bit.
        pend_d = (pend_q & ~w1c_mask) | (rise_raw & rise_en_q) | (fall_raw & fall_en_q);
        irq_d  = |(pend_q & ien_q);
    end

    // Read mux sees pre-write register values, so a same-cycle read returns old data.
    always_comb begin
        rd_val = '0;
        case (rd_sel)
            OFF_OUT:     rd_val = out_q;
            OFF_OE:      rd_val = oe_q;
            OFF_IN:      rd_val = sync;
            OFF_RISE_EN: rd_val = rise_en_q;
            OFF_FALL_EN: rd_val = fall_en_q;
            OFF_PEND:    rd_val = pend_q;
            OFF_IEN:     rd_val = ien_q;
            default:     rd_val = '0;
        endcase
        rd_data_d = '0;
        rd_data_d[GPIO_W-1:0] = rd_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            oe_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            ien_q     <= '0;
            rd_data_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            oe_q      <= oe_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            ien_q     <= ien_d;
            rd_data_q <= rd_data_d;
            irq_q     <= irq_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign gpio_o    = out_q;
    assign gpio_oe_o = oe_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_rib_gpio.sv
// Self-checking bench for rib_gpio: directed scenarios plus random traffic,
// checked against a cycle-indexed behavioural model through a read scoreboard.
module tb_rib_gpio;

    localparam int unsigned GPIO_W = 8;
    localparam int unsigned S      = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
    logic [31:0] rd_data;
    logic [7:0]  gpio_i = '0, gpio_o, gpio_oe;
    logic        irq;

    rib_gpio #(
        .GPIO_W      (GPIO_W),
        .SYNC_STAGES (S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .gpio_i    (gpio_i),
        .gpio_o    (gpio_o),
        .gpio_oe_o (gpio_oe),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model: register values, plus every gpio_i value seen at a clock edge.
    logic [7:0] m_out = '0, m_oe = '0, m_rise = '0, m_fall = '0, m_pend = '0, m_ien = '0;
    logic       m_irq = 1'b0;
    logic [7:0] samp[$];
    int         rst_idx = 0;
    logic [7:0] cur_gpio = '0;

    // Input seen at edge i; anything sampled before the last reset counts as 0.
    function automatic logic [7:0] sample(input int i);
        if (i < 0 || i < rst_idx) return 8'h00;
        return samp[i];
    endfunction

    // Value of register sel just before edge number n.
    function automatic logic [31:0] model_read(input logic [5:0] sel, input int n);
        logic [7:0] v;
        case (sel)
            6'd0:    v = m_out;
            6'd1:    v = m_oe;
            6'd2:    v = sample(n - S);
            6'd3:    v = m_rise;
            6'd4:    v = m_fall;
            6'd5:    v = m_pend;
            6'd6:    v = m_ien;
            default: v = 8'h00;
        endcase
        return {24'h0, v};
    endfunction

    // Scoreboard: expected read data queued at issue, popped when rd_data_o is due.
    logic [31:0] rd_q[$];
    logic        rd_issue = 1'b0;
    logic        rd_valid = 1'b0;

    always @(posedge clk) rd_valid <= rd_issue;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    check("rd_q_underflow", 32'd1, 32'd0);
                end else begin
                    check("rd_data", rd_data, rd_q.pop_front());
                end
            end
            check("gpio_o", {24'h0, gpio_o}, {24'h0, m_out});
            check("gpio_oe_o", {24'h0, gpio_oe}, {24'h0, m_oe});
            check("irq_o", {31'h0, irq}, {31'h0, m_irq});
        end
    end

    // One bus cycle, starting and ending at a negedge.
    task automatic step(input bit we, input logic [31:0] wa, input logic [31:0] wd,
                        input bit re, input logic [31:0] ra);
        int n;
        logic [7:0] wd8, sync_v, prev_v, rise, fall, w1c;
        logic [5:0] sel;
        logic       irq_new;
        wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra; rd_issue = re;
        gpio_i = cur_gpio;
        n = samp.size();
        if (re) rd_q.push_back(model_read(ra[7:2], n));
        @(posedge clk);
        samp.push_back(gpio_i);
        sync_v  = sample(n - S);
        prev_v  = sample(n - S - 1);
        rise    = sync_v & ~prev_v & m_rise;
        fall    = ~sync_v & prev_v & m_fall;
        irq_new = |(m_pend & m_ien);
        w1c     = 8'h00;
        wd8     = wd[7:0];
        sel     = wa[7:2];
        if (we) begin
            case (sel)
                6'd0: m_out  = wd8;
                6'd1: m_oe   = wd8;
                6'd3: m_rise = wd8;
                6'd4: m_fall = wd8;
                6'd5: w1c    = wd8;
                6'd6: m_ien  = wd8;
                6'd7: m_out  = m_out | wd8;
                6'd8: m_out  = m_out & ~wd8;
                default: ;
            endcase
        end
        m_pend = (m_pend & ~w1c) | rise | fall;
        m_irq  = irq_new;
        @(negedge clk);
        wr_en = 1'b0; rd_issue = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, a, d, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b0, 32'h0, 32'h0, 1'b1, a);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic model_reset();
        m_out = '0; m_oe = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_ien = '0;
        m_irq = 1'b0;
        rst_idx = samp.size();
        rd_q.delete();
    endtask

    initial begin
        logic [31:0] r, a;
        // Reset held for 3 cycles, released between edges.
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        check("rst_gpio_o", {24'h0, gpio_o}, 32'h0);
        check("rst_gpio_oe", {24'h0, gpio_oe}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        for (int i = 0; i <= 8; i++) rd(32'h2000_0000 + 32'(i * 4));

        // Output path, with a same-cycle read returning the pre-write value.
        step(1'b1, 32'h2000_0000, 32'hA5, 1'b1, 32'h2000_0000);
        check("out_a5", {24'h0, gpio_o}, 32'hA5);
        rd(32'h2000_0000);
        wr(32'h2000_001C, 32'h0A);
        check("out_set", {24'h0, gpio_o}, 32'hAF);
        wr(32'h2000_0020, 32'h81);
        check("out_clr", {24'h0, gpio_o}, 32'h2E);
        wr(32'h2000_0004, 32'h3C);
        rd(32'h2000_0004);

        // Rising edge on bit 0 (bit 1 also goes high but is not enabled).
        wr(32'h2000_000C, 32'h01);
        wr(32'h2000_0018, 32'h01);
        cur_gpio = 8'h03;
        idle(3);
        check("irq_before", {31'h0, irq}, 32'h0);
        rd(32'h2000_0014);
        check("irq_rise", {31'h0, irq}, 32'h1);
        rd(32'h2000_0008);

        // Falling edge on bit 1.
        wr(32'h2000_0010, 32'h02);
        cur_gpio = 8'h01;
        idle(3);
        rd(32'h2000_0014);

        // W1C on bit 0 lands in the same cycle as a fresh rising edge.
        cur_gpio = 8'h00;
        idle(3);
        cur_gpio = 8'h01;
        idle(2);
        wr(32'h2000_0014, 32'h01);
        rd(32'h2000_0014);
        check("irq_collide", {31'h0, irq}, 32'h1);
        wr(32'h2000_0014, 32'h01);
        check("irq_hold", {31'h0, irq}, 32'h1);
        rd(32'h2000_0014);
        check("irq_drop", {31'h0, irq}, 32'h0);

        // Unmapped write/read and 256-byte aliasing.
        wr(32'h2000_003C, 32'hFFFF_FFFF);
        rd(32'h2000_003C);
        for (int i = 0; i <= 6; i++) rd(32'h2000_0000 + 32'(i * 4));
        wr(32'h2000_0100, 32'h5A);
        check("alias_out", {24'h0, gpio_o}, 32'h5A);
        rd(32'h2fff_ff00);

        // Fill PEND, then reset asynchronously between edges.
        wr(32'h2000_000C, 32'hFF);
        wr(32'h2000_0010, 32'hFF);
        wr(32'h2000_0018, 32'hFF);
        wr(32'h2000_0004, 32'hFF);
        cur_gpio = ~cur_gpio;
        idle(4);
        rd(32'h2000_0014);
        check("pend_ff", rd_data, 32'hFF);
        check("irq_ff", {31'h0, irq}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_irq", {31'h0, irq}, 32'h0);
        check("async_gpio_o", {24'h0, gpio_o}, 32'h0);
        check("async_gpio_oe", {24'h0, gpio_oe}, 32'h0);
        check("async_rd_data", rd_data, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        rd(32'h2000_0014);

        // Pin high at reset release produces one rising edge.
        wr(32'h2000_000C, 32'hFF);
        idle(3);
        rd(32'h2000_0014);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            if ($urandom_range(0, 3) == 0) cur_gpio = cur_gpio ^ r[7:0];
            a = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 15) << 2)
                | 32'($urandom_range(0, 3));
            r = $urandom();
            step($urandom_range(0, 1) == 1, a, r,
                 $urandom_range(0, 1) == 1,
                 ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 15) << 2));
        end
        idle(2);
        check("rd_q_drained", 32'(rd_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
